// File: rtl/cpu_mul_pkg.sv
// cpu_mul_pkg: shared widths and the result record for the CPU multiply datapath
package cpu_mul_pkg;
  localparam int MUL_W = 32;
  localparam int HALF_W = 16;
  localparam int DEF_TAG_W = 5;
  typedef struct packed {
    logic [MUL_W-1:0] data;
    logic [DEF_TAG_W-1:0] tag;
  } mul_res_t;
endpackage

// File: rtl/cpu_mul_result_combine_if.sv
// cpu_mul_result_combine_if: issue, partial-product and result handshake bundle
interface cpu_mul_result_combine_if #(parameter int TAG_W = 5);
  import cpu_mul_pkg::*;
  logic E_mul_valid;
  logic [TAG_W-1:0] E_mul_tag;
  logic mul_en;
  logic [MUL_W-1:0] mul_p1, mul_p2, mul_p3;
  logic flush;
  logic res_valid, res_ready;
  logic [MUL_W-1:0] res_data;
  logic [TAG_W-1:0] res_tag;
  modport slave (
    input E_mul_valid, E_mul_tag, mul_p1, mul_p2, mul_p3, flush, res_ready,
    output mul_en, res_valid, res_data, res_tag
  );
  modport master (
    output E_mul_valid, E_mul_tag, mul_p1, mul_p2, mul_p3, flush, res_ready,
    input mul_en, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/cpu_mul_res_fifo.sv
// cpu_mul_res_fifo: synchronous FIFO with occupancy count and one-cycle flush
module cpu_mul_res_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  assign valid = cnt_q != '0;
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];
  assign do_pop = pop & valid;
  assign wr_d = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
  assign rd_d = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) mem_q[wr_q] <= wdata;
      if (push) wr_q <= wr_d;
      if (do_pop) rd_q <= rd_d;
      cnt_q <= cnt_q + CW'(push) - CW'(do_pop);
    end
  end
  // upstream credits must never let a result arrive at a full queue
  assert property (@(posedge clk) disable iff (reset) push |-> cnt_q != CW'(DEPTH));
endmodule

// File: rtl/cpu_mul_result_combine.sv
// cpu_mul_result_combine: folds 16x16 partial products into a*b mod 2^32, credit-gated issue
module cpu_mul_result_combine
  import cpu_mul_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  cpu_mul_result_combine_if.slave m
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic s0_vld_q, s1_vld_q;
  logic [TAG_W-1:0] s0_tag_q, s1_tag_q;
  logic [MUL_W-1:0] s1_data_q, s1_data_d;
  logic [HALF_W+1:0] mid;
  logic [CW-1:0] count;
  logic [CW:0] used;
  logic [MUL_W+TAG_W-1:0] head;
  // every op in the pipe already owns a FIFO slot, so issue only while one is free
  assign used = {1'b0, count} + (CW+1)'(s0_vld_q) + (CW+1)'(s1_vld_q);
  assign m.mul_en = used < (CW+1)'(FIFO_DEPTH);
  assign mid = (HALF_W+2)'(m.mul_p1[MUL_W-1:HALF_W]) + (HALF_W+2)'(m.mul_p2[HALF_W-1:0])
             + (HALF_W+2)'(m.mul_p3[HALF_W-1:0]);
  assign s1_data_d = {mid[HALF_W-1:0], m.mul_p1[HALF_W-1:0]};
  assign {m.res_data, m.res_tag} = head;
  always_ff @(posedge clk) begin
    if (reset) begin
      s0_vld_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s0_tag_q <= '0;
      s1_tag_q <= '0;
      s1_data_q <= '0;
    end else begin
      s0_vld_q <= m.E_mul_valid & m.mul_en & ~m.flush;
      s0_tag_q <= m.E_mul_tag;
      s1_vld_q <= s0_vld_q & ~m.flush;
      s1_tag_q <= s0_tag_q;
      s1_data_q <= s1_data_d;
    end
  end
  cpu_mul_res_fifo #(.W(MUL_W+TAG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(m.flush),
    .push(s1_vld_q & ~m.flush),
    .pop(m.res_ready),
    .wdata({s1_data_q, s1_tag_q}),
    .rdata(head),
    .valid(m.res_valid),
    .count(count)
  );
endmodule

// File: tb/tb_cpu_mul_result_combine.sv
// tb_cpu_mul_result_combine: directed vectors plus credit, flush and reset sequences
module tb_cpu_mul_result_combine;
  import cpu_mul_pkg::*;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    mul_res_t exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] a, b, pa, pb;
  int n_vec = 0;
  int errs = 0;
  vec_t vt[6];
  cpu_mul_result_combine_if #(.TAG_W(5)) bus ();
  cpu_mul_result_combine #(.TAG_W(5), .FIFO_DEPTH(2)) dut (.clk(clk), .reset(reset), .m(bus));
  always #5 clk = ~clk;
  // multiply cell model: products of the operands presented one cycle earlier
  always @(posedge clk) begin
    pa <= a;
    pb <= b;
  end
  assign bus.mul_p1 = 32'(pa[15:0]) * 32'(pb[15:0]);
  assign bus.mul_p2 = 32'(pa[15:0]) * 32'(pb[31:16]);
  assign bus.mul_p3 = 32'(pa[31:16]) * 32'(pb[15:0]);
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
    bus.E_mul_valid = 1'b1;
    a = x;
    b = y;
    bus.E_mul_tag = t;
    cyc();
    bus.E_mul_valid = 1'b0;
  endtask
  task automatic run_vec(input string nm, input vec_t v);
    int k;
    issue(v.a, v.b, v.exp.tag);
    k = 1;
    while (!bus.res_valid && k < 8) begin
      cyc();
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd3);
    chk({nm, "_data"}, bus.res_data, v.exp.data);
    chk({nm, "_tag"}, 32'(bus.res_tag), 32'(v.exp.tag));
    cyc();
  endtask
  task automatic watch(input string nm, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (bus.res_valid) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask
  initial begin
    int acc;
    vt[0] = '{32'h00012345, 32'h00000100, '{32'h01234500, 5'd3}};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, '{32'h00000001, 5'd7}};
    vt[2] = '{32'h00010000, 32'h00010000, '{32'h00000000, 5'd31}};
    vt[3] = '{32'h12345678, 32'h00000002, '{32'h2468ACF0, 5'd1}};
    vt[4] = '{32'h0000FFFF, 32'h0000FFFF, '{32'hFFFE0001, 5'd18}};
    vt[5] = '{32'h00010001, 32'h00010001, '{32'h00020001, 5'd9}};
    reset = 1'b1;
    a = '0;
    b = '0;
    bus.E_mul_valid = 1'b0;
    bus.E_mul_tag = '0;
    bus.flush = 1'b0;
    bus.res_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_data", bus.res_data, 32'd0);
    chk("rst_tag", 32'(bus.res_tag), 32'd0);
    chk("rst_mul_en", 32'(bus.mul_en), 32'd1);
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vt[i]);
    // back-to-back issue with a stalled consumer: only two credits exist
    bus.res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.E_mul_valid = 1'b1;
      a = 32'(i + 1);
      b = 32'd7;
      bus.E_mul_tag = 5'(i + 10);
      if (bus.mul_en) acc++;
      cyc();
    end
    bus.E_mul_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_mul_en_full", 32'(bus.mul_en), 32'd0);
    chk("b2b_valid", 32'(bus.res_valid), 32'd1);
    chk("b2b_head0", bus.res_data, 32'd7);
    chk("b2b_tag0", 32'(bus.res_tag), 32'd10);
    bus.res_ready = 1'b1;
    cyc();
    chk("b2b_head1", bus.res_data, 32'd14);
    chk("b2b_tag1", 32'(bus.res_tag), 32'd11);
    cyc();
    chk("b2b_drained", 32'(bus.res_valid), 32'd0);
    chk("b2b_mul_en_back", 32'(bus.mul_en), 32'd1);
    // push and pop on the same edge with one entry queued
    bus.res_ready = 1'b0;
    issue(32'd3, 32'd5, 5'd20);
    cyc();
    cyc();
    chk("pp_first_valid", 32'(bus.res_valid), 32'd1);
    issue(32'h12345678, 32'd2, 5'd21);
    cyc();
    bus.res_ready = 1'b1;
    chk("pp_head_before", bus.res_data, 32'h0000000F);
    cyc();
    bus.res_ready = 1'b0;
    chk("pp_valid_after", 32'(bus.res_valid), 32'd1);
    chk("pp_head_after", bus.res_data, 32'h2468ACF0);
    chk("pp_tag_after", 32'(bus.res_tag), 32'd21);
    chk("pp_mul_en", 32'(bus.mul_en), 32'd1);
    bus.res_ready = 1'b1;
    cyc();
    chk("pp_drained", 32'(bus.res_valid), 32'd0);
    // flush with one queued and one in flight
    bus.res_ready = 1'b0;
    issue(32'h00010001, 32'h00010001, 5'd5);
    cyc();
    cyc();
    issue(32'd9, 32'd9, 5'd6);
    cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.res_ready = 1'b1;
    chk("fl1_valid", 32'(bus.res_valid), 32'd0);
    chk("fl1_mul_en", 32'(bus.mul_en), 32'd1);
    watch("fl1_no_stale", 6);
    // flush with two in flight
    issue(32'd11, 32'd11, 5'd12);
    issue(32'd13, 32'd13, 5'd14);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("fl2_valid", 32'(bus.res_valid), 32'd0);
    chk("fl2_mul_en", 32'(bus.mul_en), 32'd1);
    watch("fl2_no_stale", 6);
    // an op issued in the flush cycle is dropped
    bus.flush = 1'b1;
    issue(32'd15, 32'd15, 5'd16);
    bus.flush = 1'b0;
    watch("fl3_issue_dropped", 6);
    // reset mid-stream behaves like flush and also clears the head storage
    bus.res_ready = 1'b0;
    issue(32'd17, 32'd17, 5'd17);
    issue(32'd19, 32'd19, 5'd19);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mrst_valid", 32'(bus.res_valid), 32'd0);
    chk("mrst_data", bus.res_data, 32'd0);
    chk("mrst_tag", 32'(bus.res_tag), 32'd0);
    chk("mrst_mul_en", 32'(bus.mul_en), 32'd1);
    bus.res_ready = 1'b1;
    watch("mrst_no_stale", 6);
    run_vec("recover", vt[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end
endmodule
